axil_gpio_responder: RTL and testbench

AXI-lite responder endpoint for a "module"/gpio leaf of the bus hierarchy; it terminates the transactions a crossbar routes to its address window.
- Holds a GPIO output register with atomic set and clear aliases.
- Exposes the GPIO inputs through a 2-flop synchroniser.
- Sits below a crossbar; one instance per gpio leaf, e.g. general_ctrls.

---
 rtl/axil_gpio_pkg.sv | 33 +++
 rtl/gpio_input_sync.sv | 27 ++
 rtl/axil_gpio_responder.sv | 191 +++++++++++++++++++
 tb/tb_axil_gpio_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_gpio_pkg.sv
// Shared constants and state types for the AXI-lite GPIO responder.
// Register offsets are word indices taken from addr[3:2].
package axil_gpio_pkg;

  localparam logic [1:0] OFF_OUT = 2'd0;
  localparam logic [1:0] OFF_IN  = 2'd1;
  localparam logic [1:0] OFF_SET = 2'd2;
  localparam logic [1:0] OFF_CLR = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Expands the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_input_sync.sv
// Two-flop synchroniser bringing the asynchronous GPIO pins into the bus clock domain.
module gpio_input_sync #(
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] async_i,
  output logic [GPIO_W-1:0] sync_o
);

  logic [GPIO_W-1:0] meta_q;
  logic [GPIO_W-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample their old inputs on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/axil_gpio_responder.sv
// AXI-lite leaf endpoint: GPIO output register with set/clear aliases and a synchronised input view.
// Write and read channels run independent state machines; one transaction outstanding on each.
module axil_gpio_responder
  import axil_gpio_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR = 32'h43C0_1000,
  parameter int                GPIO_W    = 8,
  parameter logic [GPIO_W-1:0] OUT_RESET = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [31:0]       araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);

  wr_state_e         w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0]       awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;

  rd_state_e         r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [GPIO_W-1:0] gpio_in_sync;
  logic [31:0]       out_ext, in_ext, next_ext;
  logic              unused_bits;

  gpio_input_sync #(.GPIO_W(GPIO_W)) u_sync (
    .clk     (clock),
    .rst_n   (reset),
    .async_i (gpio_in),
    .sync_o  (gpio_in_sync)
  );

  always_comb begin
    out_ext             = '0;
    out_ext[GPIO_W-1:0] = gpio_out_q;
    in_ext              = '0;
    in_ext[GPIO_W-1:0]  = gpio_in_sync;
  end

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    next_ext   = out_ext;
    gpio_out_d = gpio_out_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) w_state_d = W_EXEC;
      end
      W_EXEC: begin
        bresp_d = RESP_OKAY;
        if (awaddr_q[31:4] != BASE_ADDR[31:4]) begin
          bresp_d = RESP_SLVERR;
        end else begin
          case (awaddr_q[3:2])
            OFF_OUT: next_ext = (out_ext & ~strb_mask(wstrb_q)) | (wdata_q & strb_mask(wstrb_q));
            OFF_IN:  bresp_d  = RESP_SLVERR;
            OFF_SET: next_ext = out_ext | wdata_q;
            default: next_ext = out_ext & ~wdata_q;
          endcase
        end
        gpio_out_d = next_ext[GPIO_W-1:0];
        w_state_d  = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readies are registered so they read 0 while reset is held.
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
          if (araddr[31:4] != BASE_ADDR[31:4]) rresp_d = RESP_SLVERR;
          else if (araddr[3:2] == OFF_OUT)     rdata_d = out_ext;
          else if (araddr[3:2] == OFF_IN)      rdata_d = in_ext;
        end
      end
      R_DATA: if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      gpio_out_q <= OUT_RESET;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bresp_q    <= bresp_d;
      gpio_out_q <= gpio_out_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bresp    = bresp_q;
  assign bvalid   = (w_state_q == W_RESP);
  assign arready  = arready_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign rvalid   = (r_state_q == R_DATA);
  assign gpio_out = gpio_out_q;

  // Byte-lane address bits and bits above GPIO_W carry no meaning here.
  assign unused_bits = ^{next_ext, awaddr_q[1:0], araddr[1:0]};

endmodule

// File: tb/tb_axil_gpio_responder.sv
// Scoreboard bench for axil_gpio_responder: drivers push expectations, a negedge monitor compares.
// The reference model works on whole transactions: a write takes effect when its response appears.
module tb_axil_gpio_responder;
  import axil_gpio_pkg::*;

  localparam logic [31:0] BASE  = 32'h43C0_1000;
  localparam logic [31:0] GMASK = 32'h0000_00FF;
  localparam int          TMO   = 50;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;

  always #5 clock = ~clock;

  axil_gpio_responder #(.BASE_ADDR(BASE), .GPIO_W(8), .OUT_RESET(8'h00)) dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rd_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          aw_cyc = 0;
  int          w_cyc = 0;
  logic [31:0] model_out = '0;
  logic [31:0] in_hist[$];
  wr_t         wr_pend[$];
  rd_t         rd_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no handshake within %0d cycles (t=%0t)", name, TMO, $time);
  endtask

  // Reference model: register file semantics computed directly from the address map.
  task automatic model_write(input wr_t w, output logic [1:0] resp);
    logic [31:0] v;
    v    = model_out;
    resp = RESP_OKAY;
    if ((w.addr >> 4) != (BASE >> 4)) begin
      resp = RESP_SLVERR;
    end else begin
      case ((w.addr % 16) / 4)
        0: for (int b = 0; b < 4; b++) if (w.strb[b]) v[8*b +: 8] = w.data[8*b +: 8];
        1: resp = RESP_SLVERR;
        2: v = v | w.data;
        default: v = v & ~w.data;
      endcase
    end
    model_out = v & GMASK;
  endtask

  task automatic expect_read(input logic [31:0] a);
    rd_t e;
    e.data = '0;
    e.resp = RESP_OKAY;
    if ((a >> 4) != (BASE >> 4)) e.resp = RESP_SLVERR;
    else if ((a % 16) / 4 == 0) e.data = model_out;
    else if ((a % 16) / 4 == 1) e.data = in_hist[in_hist.size()-2];
    rd_exp.push_back(e);
  endtask

  // Pin history: entry k is gpio_in as seen at clock edge k.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      in_hist.push_back(32'(gpio_in));
      if (in_hist.size() > 8) void'(in_hist.pop_front());
    end
  end

  initial begin : monitor
    wr_t         w;
    rd_t         e;
    logic [1:0]  r;
    logic        bv_prev;
    bv_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bv_prev = 1'b0;
      end else begin
        if (bvalid && !bv_prev) begin
          if (wr_pend.size() == 0) begin
            check("b_unexpected", 32'(bvalid), 32'd0);
          end else begin
            w = wr_pend.pop_front();
            model_write(w, r);
            check("bresp", 32'(bresp), 32'(r));
            check("b_latency", cyc, ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 2);
          end
        end
        bv_prev = bvalid;
        if (bvalid) begin
          check("awready_in_resp", 32'(awready), 32'd0);
          check("wready_in_resp", 32'(wready), 32'd0);
        end
        if (rvalid) check("arready_in_data", 32'(arready), 32'd0);
        if (awvalid && awready) aw_cyc = cyc;
        if (wvalid && wready) w_cyc = cyc;
        if (arvalid && arready) expect_read(araddr);
        if (rvalid && rready) begin
          if (rd_exp.size() == 0) begin
            check("r_unexpected", 32'(rvalid), 32'd0);
          end else begin
            e = rd_exp.pop_front();
            check("rdata", rdata, e.data);
            check("rresp", 32'(rresp), 32'(e.resp));
          end
        end
        check("gpio_out", 32'(gpio_out), model_out);
      end
    end
  end

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    wr_t w;
    int  naw, nw;
    w.addr = a; w.data = d; w.strb = s;
    wr_pend.push_back(w);
    naw = 0;
    nw  = 0;
    fork
      begin
        repeat (aw_dly) @(posedge clock);
        #1 awvalid = 1'b1; awaddr = a;
        do begin @(negedge clock); naw++; end while (!awready && naw < TMO);
        if (!awready) timeout("aw_handshake");
        @(posedge clock); #1 awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge clock);
        #1 wvalid = 1'b1; wdata = d; wstrb = s;
        do begin @(negedge clock); nw++; end while (!wready && nw < TMO);
        if (!wready) timeout("w_handshake");
        @(posedge clock); #1 wvalid = 1'b0;
      end
    join
  endtask

  task automatic wait_b(input int b_dly);
    int n;
    n = 0;
    while (!bvalid && n < TMO) begin @(negedge clock); n++; end
    if (!bvalid) timeout("bvalid");
    repeat (b_dly + 1) @(posedge clock);
    #1 bready = 1'b1;
    @(posedge clock); #1 bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    send_aw_w(a, d, s, aw_dly, w_dly);
    wait_b(b_dly);
  endtask

  task automatic axi_read(input logic [31:0] a, input int a_dly, input int r_dly);
    int n;
    repeat (a_dly) @(posedge clock);
    #1 arvalid = 1'b1; araddr = a;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready && n < TMO);
    if (!arready) timeout("ar_handshake");
    @(posedge clock); #1 arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TMO) begin @(negedge clock); n++; end
    if (!rvalid) timeout("rvalid");
    repeat (r_dly + 1) @(posedge clock);
    #1 rready = 1'b1;
    @(posedge clock); #1 rready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'h10 * $urandom_range(1, 255);
      1:       return $urandom();
      default: return BASE + $urandom_range(0, 15);
    endcase
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a, a2, d;
    in_hist.push_back(32'h0);
    in_hist.push_back(32'h0);
    #1 reset = 1'b0;
    #2;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);

    axi_read(BASE, 0, 0);
    axi_write(BASE, 32'h0000_00A5, 4'b0001, 0, 0, 0);
    check("plan_out_a5", 32'(gpio_out), 32'hA5);
    axi_write(BASE, 32'h0000_00A0, 4'b1111, 0, 0, 0);
    axi_write(BASE + 32'h8, 32'h0000_000F, 4'b0000, 3, 0, 0);
    check("plan_set", 32'(gpio_out), 32'hAF);
    axi_write(BASE + 32'hC, 32'h0000_0081, 4'b0000, 0, 2, 1);
    check("plan_clr", 32'(gpio_out), 32'h2E);

    @(posedge clock); #1 gpio_in = 8'h3C;
    axi_read(BASE + 32'h4, 1, 0);
    axi_read(BASE + 32'h4, 0, 0);
    axi_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);

    axi_write(BASE + 32'h100, 32'h1234_5678, 4'b1111, 0, 0, 0);
    check("plan_oow_unchanged", 32'(gpio_out), 32'h2E);
    axi_read(BASE + 32'h100, 0, 0);
    axi_read(BASE + 32'h8, 0, 1);

    fork
      axi_write(BASE, 32'h0000_0055, 4'b0001, 0, 0, 5);
      begin repeat (4) @(posedge clock); axi_read(BASE, 0, 0); end
    join

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1 gpio_in = 8'($urandom()); end
      a  = rand_addr();
      a2 = rand_addr();
      d  = $urandom();
      case ($urandom_range(0, 2))
        0: axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        1: axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
        default: fork
          axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 4));
          axi_read(a2, $urandom_range(0, 4), $urandom_range(0, 2));
        join
      endcase
    end

    send_aw_w(BASE, 32'h0000_00FF, 4'b1111, 0, 0);
    for (int n = 0; n < TMO && !bvalid; n++) @(negedge clock);
    check("pre_reset_bvalid", 32'(bvalid), 32'd1);
    check("pre_reset_gpio_out", 32'(gpio_out), 32'hFF);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_bvalid", 32'(bvalid), 32'd0);
    check("mid_reset_gpio_out", 32'(gpio_out), 32'd0);
    check("mid_reset_rvalid", 32'(rvalid), 32'd0);
    model_out = '0;
    wr_pend.delete();
    rd_exp.delete();
    in_hist.delete();
    in_hist.push_back(32'h0);
    in_hist.push_back(32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    axi_write(BASE, 32'h0000_005A, 4'b0001, 1, 0, 0);
    check("post_reset_write", 32'(gpio_out), 32'h5A);
    axi_read(BASE, 0, 0);
    axi_read(BASE + 32'h4, 0, 0);

    repeat (3) @(posedge clock);
    check("rd_queue_drained", rd_exp.size(), 32'd0);
    check("wr_queue_drained", wr_pend.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
